// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester-side and memory-side bus of the table-memory arbiter
interface mem_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [NUM_REQ-1:0] req_ce_i;
  logic [NUM_REQ-1:0] req_we_i;
  logic [NUM_REQ*ADDR_W-1:0] req_addr_i;
  logic [NUM_REQ*4-1:0] req_width_i;
  logic [NUM_REQ*DATA_W-1:0] req_data_i;
  logic [DATA_W-1:0] req_data_o;
  logic [NUM_REQ-1:0] req_ready_o;
  logic mem_ce_o;
  logic mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [3:0] mem_width_o;
  logic [DATA_W-1:0] mem_data_o;
  logic [DATA_W-1:0] mem_data_i;
  logic mem_ready_i;
  modport slave (
    input req_ce_i, req_we_i, req_addr_i, req_width_i, req_data_i, mem_data_i, mem_ready_i,
    output req_data_o, req_ready_o, mem_ce_o, mem_we_o, mem_addr_o, mem_width_o, mem_data_o
  );
  modport master (
    output req_ce_i, req_we_i, req_addr_i, req_width_i, req_data_i, mem_data_i, mem_ready_i,
    input req_data_o, req_ready_o, mem_ce_o, mem_we_o, mem_addr_o, mem_width_o, mem_data_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin, grant-locked sharing of one table-memory port with a stall watchdog
module mem_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  mem_arbiter_if.slave bus,
  output logic gnt_valid_o,
  output logic [2:0] gnt_id_o,
  output logic stall_err_o,
  output logic [2:0] stall_id_o
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state;
  logic [2:0] last, pick;
  logic [CW-1:0] cnt;
  logic [NUM_REQ-1:0] oh;
  logic busy, sel_ce, sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [3:0] sel_width;
  logic [DATA_W-1:0] sel_data;
  int d, best;
  // distance from last+1 (with wrap) ranks requesters; the nearest active one wins
  always_comb begin
    pick = '0;
    best = NUM_REQ;
    d = 0;
    for (int j = 0; j < NUM_REQ; j++) begin
      d = j - int'(last) - 1;
      if (d < 0) d = d + NUM_REQ;
      if (bus.req_ce_i[j] && d < best) begin
        best = d;
        pick = 3'(j);
      end
    end
  end
  always_comb begin
    oh = NUM_REQ'(1) << gnt_id_o;
    sel_ce = 1'b0;
    sel_we = 1'b0;
    sel_addr = '0;
    sel_width = '0;
    sel_data = '0;
    for (int j = 0; j < NUM_REQ; j++)
      if (oh[j]) begin
        sel_ce = bus.req_ce_i[j];
        sel_we = bus.req_we_i[j];
        sel_addr = bus.req_addr_i[j*ADDR_W +: ADDR_W];
        sel_width = bus.req_width_i[j*4 +: 4];
        sel_data = bus.req_data_i[j*DATA_W +: DATA_W];
      end
  end
  assign busy = state == BUSY;
  assign bus.mem_ce_o = busy & sel_ce;
  assign bus.mem_we_o = busy & sel_we;
  assign bus.mem_addr_o = busy ? sel_addr : '0;
  assign bus.mem_width_o = busy ? sel_width : '0;
  assign bus.mem_data_o = busy ? sel_data : '0;
  assign bus.req_ready_o = (busy & bus.mem_ready_i) ? oh : '0;
  assign bus.req_data_o = bus.mem_data_i;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      gnt_id_o <= '0;
      gnt_valid_o <= 1'b0;
      last <= 3'(NUM_REQ - 1);
      cnt <= '0;
      stall_err_o <= 1'b0;
      stall_id_o <= '0;
    end else if (state == IDLE) begin
      if (|bus.req_ce_i) begin
        state <= BUSY;
        gnt_valid_o <= 1'b1;
        gnt_id_o <= pick;
        last <= pick;
        cnt <= '0;
      end
    end else begin
      if (bus.mem_ready_i) cnt <= '0;
      else if (cnt != CW'(TIMEOUT)) cnt <= cnt + 1'b1;
      if (!bus.mem_ready_i && cnt == CW'(TIMEOUT - 1)) begin
        stall_err_o <= 1'b1;
        stall_id_o <= gnt_id_o;
      end
      if (!sel_ce) begin
        state <= IDLE;
        gnt_valid_o <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus random traffic checked against a behavioural arbiter model
module tb_mem_arbiter;
  localparam int TO = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [3:0] ce = '0, we = '0;
  logic [31:0] addr[4], data[4];
  logic [3:0] width[4];
  logic [31:0] mdata = '0;
  logic mready = 1'b0;
  logic gv, serr;
  logic [2:0] gid, sid;
  mem_arbiter_if #(.NUM_REQ(4), .ADDR_W(32), .DATA_W(32)) bus();
  assign bus.req_ce_i = ce;
  assign bus.req_we_i = we;
  assign bus.req_addr_i = {addr[3], addr[2], addr[1], addr[0]};
  assign bus.req_width_i = {width[3], width[2], width[1], width[0]};
  assign bus.req_data_i = {data[3], data[2], data[1], data[0]};
  assign bus.mem_data_i = mdata;
  assign bus.mem_ready_i = mready;
  mem_arbiter #(.NUM_REQ(4), .ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave),
    .gnt_valid_o(gv), .gnt_id_o(gid), .stall_err_o(serr), .stall_id_o(sid)
  );
  int tests = 0, fails = 0;
  bit m_busy, m_err, beat;
  logic [1:0] m_gnt, m_last, m_sid;
  int m_cnt;
  int grants[$];
  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic m_reset();
    m_busy = 0; m_err = 0; m_gnt = 0; m_last = 2'd3; m_sid = 0; m_cnt = 0;
  endtask
  task automatic check_all();
    chk("mem_ce", bus.mem_ce_o, m_busy && ce[m_gnt]);
    chk("mem_we", bus.mem_we_o, m_busy && we[m_gnt]);
    chk("mem_addr", bus.mem_addr_o, m_busy ? addr[m_gnt] : 32'h0);
    chk("mem_width", bus.mem_width_o, m_busy ? width[m_gnt] : 4'h0);
    chk("mem_data", bus.mem_data_o, m_busy ? data[m_gnt] : 32'h0);
    chk("req_ready", bus.req_ready_o, (m_busy && mready) ? (4'b1 << m_gnt) : 4'b0);
    chk("req_data", bus.req_data_o, mdata);
    chk("gnt_valid", gv, m_busy);
    chk("gnt_id", gid, {1'b0, m_gnt});
    chk("stall_err", serr, m_err);
    chk("stall_id", sid, {1'b0, m_sid});
  endtask
  task automatic model_edge();
    bit found;
    logic [1:0] idx;
    beat = 0;
    if (!m_busy) begin
      if (ce != 0) begin
        found = 0;
        for (int k = 1; k <= 4; k++) begin
          idx = m_last + 2'(k);
          if (!found && ce[idx]) begin
            found = 1;
            m_gnt = idx;
          end
        end
        m_last = m_gnt; m_busy = 1; m_cnt = 0;
        grants.push_back(int'(m_gnt));
      end
    end else begin
      beat = mready && ce[m_gnt];
      if (mready) m_cnt = 0;
      else if (m_cnt < TO) begin
        m_cnt++;
        if (m_cnt == TO) begin m_err = 1; m_sid = m_gnt; end
      end
      if (!ce[m_gnt]) m_busy = 0;
    end
  endtask
  task automatic cycle();
    #1;
    check_all();
    model_edge();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    #1;
    m_reset();
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask
  initial begin
    int beats, guard;
    for (int k = 0; k < 4; k++) begin addr[k] = '0; data[k] = '0; width[k] = '0; end
    m_reset();
    #1;
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b0;
    // single requester, ready every second cycle
    ce[1] = 1; addr[1] = 32'h100; width[1] = 4'h4;
    beats = 0; guard = 0;
    while (beats < 3 && guard < 40) begin
      mready = guard[0];
      #1;
      if (m_busy && mready) begin
        chk("beat_addr", bus.mem_addr_o, 32'h100 + 32'(4 * beats));
        chk("beat_ready", bus.req_ready_o, 4'b0010);
      end
      cycle();
      if (beat) begin beats++; addr[1] += 4; end
      guard++;
    end
    chk("single_beats", beats, 3);
    ce[1] = 0; mready = 0;
    cycle();
    #1;
    chk("idle_after_release", gv, 0);
    cycle();
    chk("single_grants", grants.size(), 1);
    if (grants.size() > 0) chk("single_gnt", grants[0], 1);
    // contention 0 vs 2 right after reset
    do_reset();
    grants.delete();
    ce = 4'b0101; mready = 1; addr[0] = $urandom; addr[2] = $urandom;
    cycle(); cycle(); cycle();
    ce[0] = 0;
    cycle(); cycle(); cycle();
    ce[2] = 0;
    cycle(); cycle();
    chk("cont_grants", grants.size(), 2);
    if (grants.size() == 2) begin
      chk("cont_first", grants[0], 0);
      chk("cont_second", grants[1], 2);
    end
    // round-robin with all requesters re-requesting after each 1-beat transaction
    do_reset();
    grants.delete();
    mready = 1;
    for (int i = 0; i < 6; i++) begin
      ce = 4'hF;
      cycle(); cycle();
      ce[m_gnt] = 0;
      cycle();
    end
    chk("rr_grants", grants.size(), 6);
    if (grants.size() == 6)
      for (int i = 0; i < 6; i++) chk("rr_order", grants[i], i % 4);
    // read-modify-write by requester 3 while requester 0 waits
    grants.delete();
    ce = 4'b1001; we = 0; addr[3] = 32'h200; mready = 1;
    cycle();
    for (int i = 0; i < 4; i++) begin
      cycle();
      addr[3] += 4;
    end
    we[3] = 1; data[3] = 32'h0500_0000;
    #1;
    chk("rmw_we", bus.mem_we_o, 1);
    chk("rmw_data", bus.mem_data_o, 32'h0500_0000);
    chk("rmw_gnt", gid, 3);
    cycle();
    ce[3] = 0; we[3] = 0;
    cycle(); cycle();
    chk("rmw_grants", grants.size(), 2);
    if (grants.size() == 2) begin
      chk("rmw_first", grants[0], 3);
      chk("rmw_next", grants[1], 0);
    end
    ce = 0;
    cycle(); cycle();
    // stall watchdog
    do_reset();
    ce = 4'b0010; mready = 0;
    cycle();
    for (int i = 1; i <= 8; i++) begin
      cycle();
      if (i == 7) chk("stall_pre", serr, 0);
    end
    chk("stall_set", serr, 1);
    chk("stall_who", sid, 1);
    chk("stall_held", gv, 1);
    ce = 0;
    cycle(); cycle();
    chk("stall_sticky", serr, 1);
    // async reset mid-write
    ce = 4'b0100; we[2] = 1; data[2] = $urandom;
    cycle(); cycle();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_ce", bus.mem_ce_o, 0);
    chk("arst_valid", gv, 0);
    chk("arst_err", serr, 0);
    m_reset();
    #3;
    rst = 1'b0;
    cycle();
    chk("regrant_id", gid, 2);
    chk("regrant_valid", gv, 1);
    ce = 0; we = 0;
    cycle(); cycle();
    // random traffic
    do_reset();
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < 4; k++) begin
        if (ce[k]) ce[k] = ($urandom_range(3) != 0);
        else ce[k] = ($urandom_range(2) == 0);
        we[k] = $urandom_range(1);
        addr[k] = $urandom;
        data[k] = $urandom;
        width[k] = 4'($urandom_range(15));
      end
      mready = $urandom_range(1);
      mdata = $urandom;
      cycle();
    end
    ce = 0;
    cycle(); cycle(); cycle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
